// File: rtl/audio_pkg.sv
// Shared audio constants, stereo payload type and magnitude helper used by
// both the capture and playback I2S paths so their clock ratios always match.
package audio_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned CNT_W       = 9;
  localparam int unsigned MCLK_BIT    = 1;
  localparam int unsigned SCK_BIT     = 3;
  localparam int unsigned LRCK_BIT    = 8;
  localparam logic [3:0]  SHIFT_PHASE = 4'b1000;
  localparam int unsigned LEVEL_SHIFT = 10;
  localparam int unsigned LEVEL_W     = SAMPLE_W - 1 - LEVEL_SHIFT;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  // |x| for a two's-complement sample; the most negative value saturates.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] neg;
    neg = ~x + SAMPLE_W'(1);
    if (!x[SAMPLE_W-1]) return x[SAMPLE_W-2:0];
    if (neg[SAMPLE_W-1]) return {(SAMPLE_W-1){1'b1}};
    return neg[SAMPLE_W-2:0];
  endfunction

endpackage

// File: rtl/i2s_line_in_peak_meter.sv
// Decaying peak level of received stereo pairs for the volume display.
// Level rises instantly, falls one step per DECAY_PAIRS quieter pairs.
module peak_meter
  import audio_pkg::*;
#(
  parameter int unsigned DECAY_PAIRS = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update_i,
  input  logic [SAMPLE_W-1:0] left_i,
  input  logic [SAMPLE_W-1:0] right_i,
  output logic [LEVEL_W-1:0]  peak_level_o
);

  localparam int unsigned DCNT_W = (DECAY_PAIRS > 1) ? $clog2(DECAY_PAIRS) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_PAIRS - 1);

  logic [SAMPLE_W-2:0] mag_l_c, mag_r_c, mag_c;
  logic [LEVEL_W-1:0]  lvl_c;
  logic [LEVEL_W-1:0]  peak_q, peak_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;

  always_comb begin
    mag_l_c = abs_sat(left_i);
    mag_r_c = abs_sat(right_i);
    mag_c   = (mag_l_c > mag_r_c) ? mag_l_c : mag_r_c;
    lvl_c   = mag_c[SAMPLE_W-2 -: LEVEL_W];
    peak_d  = peak_q;
    dcnt_d  = dcnt_q;
    if (update_i) begin
      if (lvl_c >= peak_q) begin
        peak_d = lvl_c;
        dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
        dcnt_d = '0;
        if (peak_q != '0) peak_d = peak_q - LEVEL_W'(1);
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
      dcnt_q <= '0;
    end else begin
      peak_q <= peak_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign peak_level_o = peak_q;

endmodule

// File: rtl/i2s_line_in.sv
// I2S master receiver for the audio ADC: clock generation, left-justified
// 16-bit stereo deserialiser, valid/ready pair output and peak level.
module i2s_line_in
  import audio_pkg::*;
#(
  parameter int unsigned DECAY_PAIRS = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                audio_sdout,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                clr_overrun,
  output logic [LEVEL_W-1:0]  peak_level
);

  logic [CNT_W-1:0]    cnt_q;
  logic                sdout_q;
  logic [SAMPLE_W-2:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic                left_seen_q, left_seen_d;
  stereo_t             pair_q, pair_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic                shift_c, last_bit_c, left_done_c, right_done_c, emit_c;
  logic [SAMPLE_W-1:0] word_c;

  assign shift_c      = (cnt_q[SCK_BIT:0] == SHIFT_PHASE);
  assign last_bit_c   = (cnt_q[LRCK_BIT-1 -: 4] == 4'hF);
  assign word_c       = {shreg_q, sdout_q};
  assign left_done_c  = shift_c & last_bit_c & cnt_q[LRCK_BIT];
  assign right_done_c = shift_c & last_bit_c & ~cnt_q[LRCK_BIT];
  assign emit_c       = right_done_c & enable & left_seen_q;

  always_comb begin
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_seen_d = left_seen_q;
    pair_d      = pair_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (shift_c) shreg_d = word_c[SAMPLE_W-2:0];
    if (left_done_c) begin
      left_hold_d = word_c;
      left_seen_d = 1'b1;
    end
    if (!enable) left_seen_d = 1'b0;
    // An emit always wins over an accept; overwrite of an unaccepted pair is an overrun.
    if (clr_overrun) overrun_d = 1'b0;
    if (emit_c) begin
      pair_d  = '{left: left_hold_q, right: word_c};
      valid_d = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sdout_q     <= 1'b0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_seen_q <= 1'b0;
      pair_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_q + CNT_W'(1);
      sdout_q     <= audio_sdout;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_seen_q <= left_seen_d;
      pair_q      <= pair_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  peak_meter #(.DECAY_PAIRS(DECAY_PAIRS)) u_peak (
    .clk          (clk),
    .rst          (rst),
    .update_i     (emit_c),
    .left_i       (left_hold_q),
    .right_i      (word_c),
    .peak_level_o (peak_level)
  );

  assign audio_mclk   = cnt_q[MCLK_BIT];
  assign audio_sck    = cnt_q[SCK_BIT];
  assign audio_lrck   = cnt_q[LRCK_BIT];
  assign sample_left  = pair_q.left;
  assign sample_right = pair_q.right;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_line_in.sv
// Directed bench for i2s_line_in: an ADC model shifts out adc_l/adc_r
// left-justified, and pairs are checked at the edge after cnt=0x0F8.
module tb_i2s_line_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        audio_sdout;
  logic        audio_mclk, audio_lrck, audio_sck;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic [4:0]  peak_level;

  logic [15:0] adc_l = 16'h1234;
  logic [15:0] adc_r = 16'hFEDC;
  logic [8:0]  tcnt;
  logic [3:0]  bidx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [4:0]  peak;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  // Reference frame position, independent of the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt + 9'd1;
  end

  assign bidx = ~tcnt[7:4];
  assign audio_sdout = tcnt[8] ? adc_l[bidx] : adc_r[bidx];

  i2s_line_in #(.DECAY_PAIRS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .audio_sdout  (audio_sdout),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_sck    (audio_sck),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .peak_level   (peak_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [8:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tcnt != v && n < 1100);
    if (tcnt != v) begin
      checks++;
      failures++;
      $display("FAIL wait_cnt timeout: got 0x%0h expected 0x%0h", tcnt, v);
    end
  endtask

  task automatic first_valid(input logic [15:0] el, input logic [15:0] er, input logic [4:0] ep);
    int edges;
    edges = 0;
    for (int e = 1; e <= 800; e++) begin
      @(posedge clk); #1;
      if (sample_valid) begin
        edges = e;
        break;
      end
    end
    chk("first_valid_edge", 32'(edges), 32'd761);
    chk("first_left", 32'(sample_left), 32'(el));
    chk("first_right", 32'(sample_right), 32'(er));
    chk("first_peak", 32'(peak_level), 32'(ep));
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(sample_valid), 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h0400, 16'h0000, 5'd4};
    tbl[1] = '{16'h7FFF, 16'h0001, 5'd31};
    tbl[2] = '{16'h8000, 16'h0000, 5'd31};
    tbl[3] = '{16'h0000, 16'h8001, 5'd31};
    tbl[4] = '{16'h0000, 16'hF000, 5'd31};
    tbl[5] = '{16'h0000, 16'h0000, 5'd31};
    tbl[6] = '{16'h0000, 16'h0000, 5'd31};
    tbl[7] = '{16'h0000, 16'h0000, 5'd30};
    tbl[8] = '{16'h2C00, 16'hD400, 5'd30};
    tbl[9] = '{16'hFFFF, 16'h0000, 5'd30};

    // Reset values
    #23;
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_left", 32'(sample_left), 32'd0);
    chk("rst_right", 32'(sample_right), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_peak", 32'(peak_level), 32'd0);
    chk("rst_clocks", 32'({audio_mclk, audio_sck, audio_lrck}), 32'd0);

    // First pair after power-on
    @(negedge clk);
    rst = 1'b0;
    first_valid(16'h1234, 16'hFEDC, 5'd4);

    // Consecutive pairs with hand-computed peak (DECAY_PAIRS=4)
    for (int i = 0; i < 10; i++) begin
      wait_cnt(9'h100);
      adc_l = tbl[i].l;
      adc_r = tbl[i].r;
      wait_cnt(9'h0F9);
      chk($sformatf("vec%0d_valid", i), 32'(sample_valid), 32'd1);
      chk($sformatf("vec%0d_left", i), 32'(sample_left), 32'(tbl[i].l));
      chk($sformatf("vec%0d_right", i), 32'(sample_right), 32'(tbl[i].r));
      chk($sformatf("vec%0d_peak", i), 32'(peak_level), 32'(tbl[i].peak));
    end
    chk("clk_mclk", 32'(audio_mclk), 32'(tcnt[1]));
    chk("clk_sck", 32'(audio_sck), 32'(tcnt[3]));

    // Full-scale then silence: one step down every 4 pairs
    wait_cnt(9'h100);
    adc_l = 16'h8000;
    adc_r = 16'h0000;
    wait_cnt(9'h0F9);
    chk("decay_start", 32'(peak_level), 32'd31);
    wait_cnt(9'h100);
    adc_l = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      wait_cnt(9'h0F9);
      chk($sformatf("decay_k%0d", k), 32'(peak_level), 32'(31 - k / 4));
    end

    // Overrun with ready held low for three frames
    wait_cnt(9'h100);
    adc_l = 16'h1111; adc_r = 16'h2222;
    sample_ready = 1'b0;
    wait_cnt(9'h0F9);
    chk("ovr1_valid", 32'(sample_valid), 32'd1);
    chk("ovr1_overrun", 32'(overrun), 32'd0);
    wait_cnt(9'h100);
    adc_l = 16'h3333; adc_r = 16'h4444;
    wait_cnt(9'h0F9);
    chk("ovr2_left", 32'(sample_left), 32'h3333);
    chk("ovr2_overrun", 32'(overrun), 32'd1);
    wait_cnt(9'h100);
    adc_l = 16'h5555; adc_r = 16'h6666;
    wait_cnt(9'h0F9);
    chk("ovr3_valid", 32'(sample_valid), 32'd1);
    chk("ovr3_data", {sample_left, sample_right}, 32'h5555_6666);
    chk("ovr3_overrun", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_valid_held", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    @(posedge clk); #1;
    chk("accept_drop", 32'(sample_valid), 32'd0);

    // Accept on the very cycle of a new emit
    sample_ready = 1'b0;
    wait_cnt(9'h100);
    adc_l = 16'h0A0A; adc_r = 16'h0B0B;
    wait_cnt(9'h0F9);
    chk("pulse_pre_valid", 32'(sample_valid), 32'd1);
    wait_cnt(9'h100);
    adc_l = 16'h0C0C; adc_r = 16'h0D0D;
    wait_cnt(9'h0F8);
    sample_ready = 1'b1;
    @(posedge clk); #1;
    sample_ready = 1'b0;
    chk("pulse_valid", 32'(sample_valid), 32'd1);
    chk("pulse_data", {sample_left, sample_right}, 32'h0C0C_0D0D);
    chk("pulse_overrun", 32'(overrun), 32'd0);
    sample_ready = 1'b1;
    @(posedge clk); #1;
    chk("pulse_drop", 32'(sample_valid), 32'd0);

    // Enable dropped mid-left-word, restored during the next right half
    wait_cnt(9'h100);
    adc_l = 16'h7777; adc_r = 16'h0123;
    wait_cnt(9'h150);
    enable = 1'b0;
    chk("en_lrck_runs", 32'(audio_lrck), 32'd1);
    wait_cnt(9'h080);
    enable = 1'b1;
    wait_cnt(9'h0F9);
    chk("en_no_pair", 32'(sample_valid), 32'd0);
    wait_cnt(9'h0F9);
    chk("en_pair_back", 32'(sample_valid), 32'd1);
    chk("en_pair_data", {sample_left, sample_right}, 32'h7777_0123);

    // Asynchronous reset mid-frame, then power-on recovery timing
    sample_ready = 1'b0;
    wait_cnt(9'h100);
    adc_l = 16'h4321; adc_r = 16'h8765;
    wait_cnt(9'h0F9);
    chk("pre_rst_valid", 32'(sample_valid), 32'd1);
    wait_cnt(9'h1A3);
    chk("pre_rst_mclk", 32'(audio_mclk), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(sample_valid), 32'd0);
    chk("arst_data", {sample_left, sample_right}, 32'd0);
    chk("arst_peak", 32'(peak_level), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_clocks", 32'({audio_mclk, audio_sck, audio_lrck}), 32'd0);
    adc_l = 16'h0400; adc_r = 16'hFC00;
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_valid(16'h0400, 16'hFC00, 5'd1);

    // Low peak decays to zero and stays there
    wait_cnt(9'h100);
    adc_l = 16'h0000; adc_r = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      wait_cnt(9'h0F9);
      chk($sformatf("floor_k%0d", k), 32'(peak_level), (k < 4) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
